// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: data word width and word type.
package cpu_pkg;

  localparam int DW = 32;

  typedef logic [DW-1:0] word_t;

endpackage : cpu_pkg

// File: rtl/dmem.sv
// Word-organised data memory for the single-cycle CPU load/store path.
// Combinational read, synchronous write, asynchronous active-low clear of
// every word. The byte address is reduced to a word index from bits
// [AW+1:2]; the byte offset and the bits above the array are discarded,
// so the address space wraps modulo DEPTH*4 bytes.
// DEPTH must be a power of two and at least 4.
module dmem
  import cpu_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [31:0] a,
  input  word_t       wd,
  output word_t       rd
);

  localparam int AW = $clog2(DEPTH);

  // Flop-based storage: the whole array is cleared by reset, which rules out
  // block RAM inference.
  word_t         r_mem [DEPTH];
  logic [AW-1:0] w_idx;

  // The byte offset and the aliasing high bits do not take part in decoding.
  logic          w_unused_addr_bits;

  assign w_idx              = a[AW+1:2];
  assign w_unused_addr_bits = ^{a[31:AW+2], a[1:0]};

  // Write port: clear everything while reset is low, otherwise store one full word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (we) begin
      r_mem[w_idx] <= wd;
    end
  end

  // Read port: zero-latency mux with no write bypass, so a same-cycle write
  // becomes visible only after the clock edge.
  assign rd = r_mem[w_idx];

endmodule : dmem

// File: tb/tb_dmem.sv
// Directed, self-checking bench for dmem with DEPTH = 64.
module tb_dmem;
  import cpu_pkg::*;

  typedef struct {
    string tag;
    word_t exp;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [31:0] a;
  word_t       wd;
  word_t       rd;

  exp_t        sb_q[$];
  int          checks;
  int          errors;

  dmem #(.DEPTH(64)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .a     (a),
    .wd    (wd),
    .rd    (rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pop the oldest expectation and compare it with the current read data.
  task automatic check_rd();
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty: no expected value queued, rd=%h", rd);
      return;
    end
    e = sb_q.pop_front();
    checks++;
    assert (rd === e.exp) else begin
      errors++;
      $error("FAIL %s: rd=%h expected=%h", e.tag, rd, e.exp);
    end
    $display("check %0d %s a=%h rd=%h expected=%h", checks, e.tag, a, rd, e.exp);
  endtask

  // Apply an address, queue the expected read value, then compare after settling.
  task automatic read_expect(input string tag, input logic [31:0] addr, input word_t exp);
    a = addr;
    sb_q.push_back('{tag: tag, exp: exp});
    #1;
    check_rd();
  endtask

  // One write lasting a single rising edge; inputs change at the falling edge.
  task automatic write_word(input logic [31:0] addr, input word_t data);
    @(negedge clk);
    we = 1'b1;
    a  = addr;
    wd = data;
    @(posedge clk);
    #1;
    we = 1'b0;
    $display("write a=%h wd=%h", addr, data);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    we     = 1'b0;
    a      = 32'h0;
    wd     = 32'h0;

    // Reset state, observed while reset is still held
    #12;
    read_expect("reset_hold_0x0", 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset then read
    read_expect("post_reset_0x0", 32'h0, 32'h0);
    read_expect("post_reset_0x4", 32'h4, 32'h0);
    read_expect("post_reset_0xFC", 32'hFC, 32'h0);

    // Write with read-during-write: old data before the edge, new after
    @(negedge clk);
    we = 1'b1;
    a  = 32'h4;
    wd = 32'hAABBCCDD;
    read_expect("rdw_before_edge", 32'h4, 32'h0);
    @(posedge clk);
    #1;
    read_expect("rdw_after_edge", 32'h4, 32'hAABBCCDD);
    we = 1'b0;
    @(negedge clk);
    read_expect("read_0x4", 32'h4, 32'hAABBCCDD);

    // Second word, no disturbance of the first
    write_word(32'h8, 32'h11223344);
    read_expect("read_0x8", 32'h8, 32'h11223344);
    read_expect("read_0x4_undisturbed", 32'h4, 32'hAABBCCDD);

    // Write-enable low across an edge leaves the word unchanged
    @(negedge clk);
    we = 1'b0;
    a  = 32'h4;
    wd = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    read_expect("we_low_0x4", 32'h4, 32'hAABBCCDD);

    // Aliasing: byte offset and high bits discarded
    read_expect("alias_0x5", 32'h5, 32'hAABBCCDD);
    read_expect("alias_0x104", 32'h104, 32'hAABBCCDD);
    write_word(32'h10B, 32'h12345678);
    read_expect("alias_write_0x10B_read_0x8", 32'h8, 32'h12345678);
    read_expect("alias_write_keeps_0x4", 32'h4, 32'hAABBCCDD);

    // Extra word to check write lands at the top of the array
    write_word(32'hFC, 32'h0F0F0F0F);
    read_expect("top_word_0xFC", 32'hFC, 32'h0F0F0F0F);
    read_expect("top_alias_0x1FF", 32'h1FF, 32'h0F0F0F0F);

    // Async reset mid-run: drop rst_n between edges while a = 0x8
    @(negedge clk);
    a = 32'h8;
    #2;
    rst_n = 1'b0;
    read_expect("async_reset_0x8", 32'h8, 32'h0);

    // Write attempted while reset is low is lost
    @(negedge clk);
    we = 1'b1;
    a  = 32'hC;
    wd = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    read_expect("write_in_reset_0xC", 32'hC, 32'h0);
    read_expect("after_reset_0x4", 32'h4, 32'h0);
    read_expect("after_reset_0xFC", 32'hFC, 32'h0);

    // Normal operation resumes after reset
    write_word(32'hC, 32'h5A5A5A5A);
    read_expect("resume_0xC", 32'hC, 32'h5A5A5A5A);

    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_dmem
